// File: rtl/dec_scan.sv
// dec_scan: registered N-to-2^N one-hot decoder with direct select and auto-scan
// mode that rotates the active output, holding each index for DWELL cycles.
module dec_scan #(
  parameter int N          = 2,
  parameter int DWELL      = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            E,
  input  logic            mode,
  input  logic [N-1:0]    A,
  output logic [2**N-1:0] Y,
  output logic [N-1:0]    idx,
  output logic            wrap
);
  localparam int M = 2**N;
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [N-1:0]  idx_nx;
  logic          wrap_nx;
  logic [M-1:0]  y_nx;
  logic          adv;
  always_comb begin
    state_nx = !E ? IDLE : mode ? SCAN : DIRECT;
    cnt_nx   = '0;
    idx_nx   = '0;
    wrap_nx  = 1'b0;
    adv      = cnt == LAST;
    if (state_nx == DIRECT || (state_nx == SCAN && state != SCAN))
      idx_nx = A;
    else if (state_nx == SCAN) begin
      cnt_nx  = adv ? '0 : cnt + 1'b1;
      idx_nx  = adv ? idx + 1'b1 : idx;
      wrap_nx = adv && (&idx);
    end
    // polarity is folded in before the register so Y drives pins directly
    y_nx = (state_nx == IDLE ? '0 : M'(1) << idx_nx) ^ {M{ACTIVE_LOW}};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
      Y     <= {M{ACTIVE_LOW}};
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      wrap  <= wrap_nx;
      Y     <= y_nx;
    end
endmodule

// File: tb/tb_dec_scan.sv
// tb_dec_scan: randomized self-checking bench for dec_scan against a
// behavioural model (scan index = start + elapsed/DWELL, modulo 2^N).
module tb_dec_scan;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en[2];
  logic       md[2];
  logic [2:0] aa[2];
  logic [3:0] y0, y2;
  logic [1:0] i0, i2;
  logic       w0, w2;
  logic [7:0] y1;
  logic [2:0] i1;
  logic       w1;
  int errors = 0, checks = 0;
  int ms[2], s[2], t[2];

  always #5 clk = ~clk;

  dec_scan #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .E(en[0]), .mode(md[0]), .A(aa[0][1:0]),
    .Y(y0), .idx(i0), .wrap(w0));
  dec_scan #(.N(3), .DWELL(1), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .E(en[1]), .mode(md[1]), .A(aa[1]),
    .Y(y1), .idx(i1), .wrap(w1));
  dec_scan #(.N(2), .DWELL(4), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .E(en[0]), .mode(md[0]), .A(aa[0][1:0]),
    .Y(y2), .idx(i2), .wrap(w2));

  // model: ms 0=idle 1=direct 2=scanning; s=start index; t=cycles since scan entry
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 2; i++)
      if (!rst_n || !en[i]) ms[i] <= 0;
      else if (!md[i]) begin ms[i] <= 1; s[i] <= int'(aa[i]); end
      else if (ms[i] != 2) begin ms[i] <= 2; s[i] <= int'(aa[i]); t[i] <= 0; end
      else t[i] <= t[i] + 1;

  function automatic int eidx(int i, int dw, int m);
    if (ms[i] == 0) return 0;
    if (ms[i] == 1) return s[i] % m;
    return (s[i] + t[i] / dw) % m;
  endfunction
  function automatic logic ewrap(int i, int dw, int m);
    return ms[i] == 2 && t[i] > 0 && t[i] % dw == 0 && eidx(i, dw, m) == 0;
  endfunction
  function automatic logic [7:0] ey(int i, int dw, int m);
    return ms[i] == 0 ? 8'd0 : 8'd1 << eidx(i, dw, m);
  endfunction

  task automatic drive0(logic e, logic m, logic [1:0] a);
    en[0] = e; md[0] = m; aa[0] = {1'b0, a};
  endtask

  task automatic test_reset;
    drive0(0, 0, 0); en[1] = 0; md[1] = 0; aa[1] = 0;
    @(negedge clk); #2 rst_n = 1'b0; #1;
    checks += 3;
    if ({y0, i0, w0} !== 7'b0) begin errors++; $display("FAIL reset_u0 got Y=%b idx=%0d wrap=%b exp 0000/0/0", y0, i0, w0); end
    if ({y2, i2, w2} !== 7'b1111_00_0) begin errors++; $display("FAIL reset_u2 got Y=%b idx=%0d wrap=%b exp 1111/0/0", y2, i2, w2); end
    if ({y1, i1, w1} !== 12'b0) begin errors++; $display("FAIL reset_u1 got Y=%b idx=%0d wrap=%b exp 0/0/0", y1, i1, w1); end
    @(posedge clk); #1;
    checks++;
    if (y0 !== 4'b0000 || y2 !== 4'b1111) begin errors++; $display("FAIL reset_hold got Y0=%b Y2=%b exp 0000/1111", y0, y2); end
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({y0, i0, w0} !== 7'b0 || y2 !== 4'b1111 || y1 !== 8'b0) begin
        errors++; $display("FAIL idle got Y0=%b Y2=%b Y1=%b exp 0000/1111/0", y0, y2, y1);
      end
    end
  endtask

  task automatic test_direct;
    logic [1:0] sw[4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [3:0] yl[4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0100};
    logic [3:0] yh[4] = '{4'b1110, 4'b1101, 4'b0111, 4'b1011};
    logic [7:0] e;
    for (int k = 0; k < 4; k++) begin
      drive0(1, 0, sw[k]);
      en[1] = 1; md[1] = 0; aa[1] = 3'($urandom_range(0, 7));
      @(negedge clk);
      checks += 3;
      if (y0 !== yl[k] || i0 !== sw[k] || w0 !== 1'b0) begin errors++; $display("FAIL direct_u0 A=%0d got Y=%b idx=%0d wrap=%b exp %b/%0d/0", sw[k], y0, i0, w0, yl[k], sw[k]); end
      if (y2 !== yh[k] || i2 !== sw[k]) begin errors++; $display("FAIL direct_u2 A=%0d got Y=%b idx=%0d exp %b/%0d", sw[k], y2, i2, yh[k], sw[k]); end
      e = ey(1, 1, 8);
      if (y1 !== e || i1 !== 3'(eidx(1, 1, 8)) || w1 !== 1'b0) begin errors++; $display("FAIL direct_u1 got Y=%b idx=%0d exp Y=%b", y1, i1, e); end
    end
    drive0(0, 0, 2'd3);
    @(negedge clk);
    checks++;
    if (y0 !== 4'b0000 || y2 !== 4'b1111 || i0 !== 2'd0) begin errors++; $display("FAIL direct_off got Y0=%b Y2=%b idx=%0d exp 0000/1111/0", y0, y2, i0); end
  endtask

  task automatic test_scan;
    int last = -1, nwrap = 0;
    logic [7:0] e;
    drive0(1, 1, 2'd2);
    en[1] = 1; md[1] = 1; aa[1] = 3'd6;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      aa[0] = 3'($urandom_range(0, 3));
      aa[1] = 3'($urandom_range(0, 7));
      checks += 3;
      e = ey(0, 3, 4);
      if (y0 !== e[3:0] || i0 !== 2'(eidx(0, 3, 4)) || w0 !== ewrap(0, 3, 4)) begin
        errors++; $display("FAIL scan_u0 c=%0d got Y=%b idx=%0d wrap=%b exp Y=%b idx=%0d wrap=%b", c, y0, i0, w0, e[3:0], eidx(0, 3, 4), ewrap(0, 3, 4));
      end
      e = ey(0, 4, 4);
      if (y2 !== ~e[3:0] || i2 !== 2'(eidx(0, 4, 4)) || w2 !== ewrap(0, 4, 4)) begin
        errors++; $display("FAIL scan_u2 c=%0d got Y=%b idx=%0d wrap=%b exp Y=%b idx=%0d", c, y2, i2, w2, ~e[3:0], eidx(0, 4, 4));
      end
      e = ey(1, 1, 8);
      if (y1 !== e || i1 !== 3'(eidx(1, 1, 8)) || w1 !== ewrap(1, 1, 8) || $countones(y1) != 1) begin
        errors++; $display("FAIL scan_u1 c=%0d got Y=%b idx=%0d wrap=%b exp Y=%b idx=%0d", c, y1, i1, w1, e, eidx(1, 1, 8));
      end
      if (w0) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 12) begin errors++; $display("FAIL wrap_period got %0d exp 12", c - last); end
        end
        last = c; nwrap++;
      end
    end
    checks++;
    if (nwrap != 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", nwrap); end
  endtask

  task automatic test_mid;
    drive0(1, 1, 2'd0);
    repeat (2) @(negedge clk);
    drive0(1, 0, 2'd1);
    @(negedge clk);
    checks++;
    if (y0 !== 4'b0010 || y2 !== 4'b1101) begin errors++; $display("FAIL scan_to_direct got Y0=%b Y2=%b exp 0010/1101", y0, y2); end
    drive0(1, 1, 2'd3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      aa[0] = 3'd1;
      checks++;
      if (y0 !== 4'b1000 || w0 !== 1'b0) begin errors++; $display("FAIL direct_to_scan c=%0d got Y=%b wrap=%b exp 1000/0", c, y0, w0); end
    end
    @(negedge clk);
    checks++;
    if (y0 !== 4'b0001 || w0 !== 1'b1 || y2 !== 4'b0111) begin errors++; $display("FAIL mid_wrap got Y0=%b wrap=%b Y2=%b exp 0001/1/0111", y0, w0, y2); end
    @(negedge clk);
    drive0(0, 1, 2'd3);
    @(negedge clk);
    checks++;
    if (y0 !== 4'b0000 || y2 !== 4'b1111 || w0 !== 1'b0) begin errors++; $display("FAIL scan_disable got Y0=%b Y2=%b exp 0000/1111", y0, y2); end
    drive0(1, 1, 2'd3);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; #1;
    checks++;
    if ({y0, i0, w0} !== 7'b0 || {y2, i2, w2} !== 7'b1111_00_0) begin errors++; $display("FAIL mid_reset got Y0=%b idx=%0d wrap=%b Y2=%b exp 0000/0/0/1111", y0, i0, w0, y2); end
    @(posedge clk); #1;
    checks++;
    if (w0 !== 1'b0 || y0 !== 4'b0000 || w2 !== 1'b0) begin errors++; $display("FAIL mid_reset_hold got Y0=%b wrap=%b exp 0000/0", y0, w0); end
    drive0(0, 0, 2'd0);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic [7:0] e;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        en[i] = $urandom_range(0, 15) != 0;
        md[i] = $urandom_range(0, 9) == 0 ? ~md[i] : md[i];
        aa[i] = i == 0 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      checks += 3;
      e = ey(0, 3, 4);
      if (y0 !== e[3:0] || i0 !== 2'(eidx(0, 3, 4)) || w0 !== ewrap(0, 3, 4)) begin
        errors++; $display("FAIL rand_u0 c=%0d got Y=%b idx=%0d wrap=%b exp Y=%b idx=%0d wrap=%b", c, y0, i0, w0, e[3:0], eidx(0, 3, 4), ewrap(0, 3, 4));
      end
      e = ey(0, 4, 4);
      if (y2 !== ~e[3:0] || i2 !== 2'(eidx(0, 4, 4)) || w2 !== ewrap(0, 4, 4)) begin
        errors++; $display("FAIL rand_u2 c=%0d got Y=%b idx=%0d wrap=%b exp Y=%b idx=%0d wrap=%b", c, y2, i2, w2, ~e[3:0], eidx(0, 4, 4), ewrap(0, 4, 4));
      end
      e = ey(1, 1, 8);
      if (y1 !== e || i1 !== 3'(eidx(1, 1, 8)) || w1 !== ewrap(1, 1, 8)) begin
        errors++; $display("FAIL rand_u1 c=%0d got Y=%b idx=%0d wrap=%b exp Y=%b idx=%0d wrap=%b", c, y1, i1, w1, e, eidx(1, 1, 8), ewrap(1, 1, 8));
      end
    end
  endtask

  initial begin
    test_reset;
    test_direct;
    test_scan;
    test_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised, registered N-to-2^N one-hot decoder with enable and an auto-scan mode. It is the next generation of the team's 2-to-4 decoder. It generalises select width and output polarity. It adds a clocked scan mode that rotates the active output with a programmable dwell time, for driving digit and row selects on multiplexed displays and keypads. All outputs are registered, so the block can sit directly in front of the board I/O.

## Interface
- `N`, default 2: select width; the block drives 2^N outputs. Legal range is N >= 1.
- `DWELL`, default 4: number of clock cycles each output stays active in scan mode. Legal range is DWELL >= 1.
- `ACTIVE_LOW`, default 0: output polarity. When 1, `Y` is bitwise inverted at the output register (active output 0, all others 1).
- `clk` in 1: clock; the only clock. All state changes on its rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `E` in 1: enable. When 0, all outputs are inactive.
- `mode` in 1: 0 selects direct mode, 1 selects scan mode.
- `A` in N: select index in direct mode; start index on entry to scan mode.
- `Y` out 2^N: registered one-hot decode. Bit i is active when `idx` == i.
- `idx` out N: currently active index. Reads 0 in IDLE.
- `wrap` out 1: one-cycle pulse when the scan index rolls over from 2^N-1 to 0.

## Operation
- Internal state register: IDLE, DIRECT, SCAN.
- Dwell counter `cnt`: internal, width clog2(DWELL), minimum 1 bit.
- All transitions are evaluated on each rising edge of `clk`, using `E` and `mode` sampled at that edge.
- **Next state:**
  - E=0 goes to IDLE.
  - E=1 and mode=0 goes to DIRECT.
  - E=1 and mode=1 goes to SCAN.
- **IDLE (next):** `Y` all inactive, `idx` 0, `cnt` 0, `wrap` 0.
- **DIRECT (next):** `idx` <= A, `Y` <= onehot(A), `cnt` <= 0, `wrap` <= 0. `A` is re-sampled every cycle.
- **SCAN entry** (current state not SCAN): `idx` <= A, `Y` <= onehot(A), `cnt` <= 0, `wrap` <= 0.
- **SCAN hold** (current SCAN, cnt != DWELL-1): `cnt` <= cnt+1. `idx` and `Y` hold. `wrap` <= 0.
- **SCAN advance** (current SCAN, cnt == DWELL-1):
  - `cnt` <= 0.
  - `idx` <= (idx+1) mod 2^N.
  - `Y` <= onehot of the new idx.
  - `wrap` <= 1 if the old idx == 2^N-1, else 0.
- `A` is ignored in SCAN except on entry.
- Every index is active for exactly DWELL cycles. A full scan period is DWELL·2^N cycles.
- With DWELL=1, the index advances every cycle and `cnt` stays at 0.
- Index arithmetic wraps modulo 2^N. There is no saturation.
- **Mode switches mid-operation:**
  - SCAN to DIRECT: the next edge shows onehot(A). Dwell progress is discarded.
  - DIRECT to SCAN: scan starts from the current `A`, with a full dwell period.
  - E falling mid-scan: IDLE on the next edge. Re-enabling restarts the scan from `A`; the scan does not resume.
- **Invariants:** `Y` is exactly one-hot (or all inactive in IDLE). It is never multi-hot.
- **Polarity:** ACTIVE_LOW applies only to `Y`. The values above are logical. `idx` and `wrap` are always active-high.

## Timing
- **Reset** (rst_n=0, asynchronous, immediate):
  - State IDLE, `cnt` 0, `idx` 0, `wrap` 0.
  - `Y` all 0 when ACTIVE_LOW=0, all 1 when ACTIVE_LOW=1.
  - These values hold while rst_n=0, regardless of `clk`.
- Reset release is sampled synchronously. The first functional update is on the first rising edge at which rst_n=1.
- Latency is one cycle for every path. Inputs sampled at edge k appear on `Y`, `idx`, `wrap` after edge k.
- There is no combinational path from inputs to outputs.
- **Scan with a fixed start:** with entry at edge k and start index s:
  - Y=onehot(s) for edges k..k+DWELL-1.
  - Y=onehot(s+1) from edge k+DWELL.
- `wrap` is high for exactly one cycle, coincident with the first cycle of idx=0 after a rollover.
- `wrap` is never high on scan entry, even when A=0.
- **Reset asserted mid-scan:** outputs go to their reset values immediately. No `wrap` pulse is produced.

## Test plan
- **Reset/IDLE:** N=2, ACTIVE_LOW=0. Assert rst_n=0 between edges. Required: Y=0000, idx=0, wrap=0 immediately. Then release with E=0: outputs stay 0000 across 5 edges.
- **Direct sweep:** E=1, mode=0, A=0,1,3,2, one value per cycle. Required: Y=0001, 0010, 1000, 0100, each one edge after its A. Then E=0: Y=0000 next edge.
- **Scan with wrap:** N=2, DWELL=3, enter with A=2. Required: Y=0100 for 3 cycles, then 1000 for 3, then 0001 with wrap=1 only on its first cycle, then 0010. Repeat for 2 full periods and check that wrap fires every 12 cycles.
- **DWELL=1 and N=3:** enter with A=6. Required: idx=6,7,0,1,... on consecutive edges, with wrap=1 in the cycle idx=0. Y is one-hot over 8 bits throughout.
- **Mid-operation changes:**
  - mode 1→0 mid-dwell with A=1: Y=0010 next edge.
  - Then mode 0→1 with A=3: Y=1000 for a full DWELL.
  - E 1→0 mid-scan: Y=0000 next edge.
  - rst_n pulse mid-scan: immediate reset values, no wrap.
- **ACTIVE_LOW=1:** repeat the direct sweep. Required: Y=1110, 1101, 0111, 1011. Reset and IDLE give Y=1111.
